// File: rtl/data_mem_if.sv
// Request/response bus between the core MEM stage and the data memory controller.
// The core drives through the master modport and the memory answers through the slave modport.
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-addressed little-endian data memory with sub-word loads/stores, fault detection
// and a fixed, parameterised response latency. One request is outstanding at a time.
module data_mem_ctrl #(
  parameter int unsigned SZ      = 4096,
  parameter int unsigned LATENCY = 1
) (
  input logic       clk,
  input logic       rst_n,
  data_mem_if.slave bus
);
  localparam int unsigned AW       = $clog2(SZ);
  localparam logic [2:0]  CNT_INIT = (LATENCY >= 2) ? 3'(LATENCY - 32'd2) : 3'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e        state_q;
  logic [2:0]    cnt_q;
  logic          req_ready_q;
  logic          resp_valid_q;
  logic          resp_fault_q;
  logic [31:0]   resp_rdata_q;
  logic [7:0]    mem_q [SZ];

  logic          accept_s;
  logic          fault_s;
  logic [2:0]    nbytes_s;
  logic [32:0]   last_byte_s;
  logic [AW-1:0] idx_s [4];
  logic [31:0]   raw_s;
  logic [31:0]   rdata_d;

  assign accept_s       = bus.req_valid & req_ready_q;
  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_fault = resp_fault_q;

  // Access width, fault decode and lane addresses for the request on the bus.
  always_comb begin
    case (bus.req_size)
      2'b00:   nbytes_s = 3'd1;
      2'b01:   nbytes_s = 3'd2;
      2'b10:   nbytes_s = 3'd4;
      default: nbytes_s = 3'd4;
    endcase
    // 33-bit sum so an address near 2^32 cannot wrap back into range.
    last_byte_s = {1'b0, bus.req_addr} + {30'd0, nbytes_s} - 33'd1;
    fault_s = (bus.req_size == 2'b11)
            | ((bus.req_size == 2'b01) & bus.req_addr[0])
            | ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00))
            | (last_byte_s >= 33'(SZ));
    for (int i = 0; i < 4; i++) begin
      idx_s[i] = bus.req_addr[AW-1:0] + AW'(i);
    end
    raw_s = {mem_q[idx_s[3]], mem_q[idx_s[2]], mem_q[idx_s[1]], mem_q[idx_s[0]]};
  end

  // Sign- or zero-extension of the raw little-endian load data.
  always_comb begin
    case (bus.req_size)
      2'b00: begin
        if (bus.req_unsigned) begin
          rdata_d = {24'd0, raw_s[7:0]};
        end else begin
          rdata_d = {{24{raw_s[7]}}, raw_s[7:0]};
        end
      end
      2'b01: begin
        if (bus.req_unsigned) begin
          rdata_d = {16'd0, raw_s[15:0]};
        end else begin
          rdata_d = {{16{raw_s[15]}}, raw_s[15:0]};
        end
      end
      default: rdata_d = raw_s;
    endcase
  end

  // Storage array: byte lanes written at the accept edge of a legal store, never reset.
  always_ff @(posedge clk) begin
    if (accept_s && bus.req_we && !fault_s) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < nbytes_s) begin
          mem_q[idx_s[i]] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Request/latency/response sequencing with all bus outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_fault_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            resp_fault_q <= fault_s;
            resp_rdata_q <= (fault_s || bus.req_we) ? 32'd0 : rdata_d;
            req_ready_q  <= 1'b0;
            if (LATENCY <= 32'd1) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_q == 3'd0) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end else begin
            state_q <= S_RESP;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a LATENCY=3 instance for the functional traffic
// and a LATENCY=4 instance for reset during an outstanding load.
module tb_data_mem_ctrl;
  localparam int unsigned SZ = 4096;
  localparam int unsigned LAT = 3;
  localparam int unsigned LAT4 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  logic [32:0] sb_q [$];

  data_mem_if m3();
  data_mem_if m4();

  data_mem_ctrl #(.SZ(SZ), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(m3)
  );

  data_mem_ctrl #(.SZ(SZ), .LATENCY(LAT4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(m4)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // One complete request on the LATENCY=3 port. While it is outstanding a bogus store to
  // 0x10 is kept on the request lines; it must be ignored.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                     input logic [31:0] er, input logic ef, input int hold);
    int t;
    logic [32:0] exp;
    sb_q.push_back({ef, er});
    @(negedge clk);
    m3.req_valid = 1'b1; m3.req_we = we; m3.req_addr = addr;
    m3.req_size = sz; m3.req_unsigned = uns; m3.req_wdata = wd;
    t = 0;
    while (m3.req_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_val({tag, "/accept"}, 32'(t < 20), 32'd1);
    @(negedge clk);
    m3.req_we = 1'b1; m3.req_addr = 32'h10; m3.req_size = 2'b10;
    m3.req_unsigned = 1'b0; m3.req_wdata = 32'hBAD0BAD0;
    t = 1;
    while (m3.resp_valid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_val({tag, "/latency"}, 32'(t), LAT);
    for (int k = 0; k < hold; k++) begin
      check_val({tag, "/hold_rdy"}, {31'd0, m3.req_ready}, 32'd0);
      check_val({tag, "/hold_vld"}, {31'd0, m3.resp_valid}, 32'd1);
      check_val({tag, "/hold_rd"}, m3.resp_rdata, er);
      @(negedge clk);
    end
    m3.resp_ready = 1'b1;
    exp = sb_q.pop_front();
    check_val({tag, "/rdata"}, m3.resp_rdata, exp[31:0]);
    check_val({tag, "/fault"}, {31'd0, m3.resp_fault}, {31'd0, exp[32]});
    @(negedge clk);
    m3.resp_ready = 1'b0;
    m3.req_valid = 1'b0;
    check_val({tag, "/vld_drop"}, {31'd0, m3.resp_valid}, 32'd0);
    check_val({tag, "/rdy_back"}, {31'd0, m3.req_ready}, 32'd1);
  endtask

  initial begin
    int t;
    logic seen;
    logic [32:0] exp;
    m3.req_valid = 1'b0; m3.req_we = 1'b0; m3.req_addr = 32'd0; m3.req_size = 2'b00;
    m3.req_unsigned = 1'b0; m3.req_wdata = 32'd0; m3.resp_ready = 1'b0;
    m4.req_valid = 1'b0; m4.req_we = 1'b0; m4.req_addr = 32'd0; m4.req_size = 2'b00;
    m4.req_unsigned = 1'b0; m4.req_wdata = 32'd0; m4.resp_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_val("rst/resp_valid", {31'd0, m3.resp_valid}, 32'd0);
    check_val("rst/req_ready", {31'd0, m3.req_ready}, 32'd0);
    check_val("rst/rdata", m3.resp_rdata, 32'd0);
    check_val("rst/fault", {31'd0, m3.resp_fault}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst/ready_after", {31'd0, m3.req_ready}, 32'd1);

    txn("sw10",    1'b1, 32'h10,       2'b10, 1'b0, 32'h12345678, 32'h0,        1'b0, 0);
    txn("lw10",    1'b0, 32'h10,       2'b10, 1'b0, 32'h0,        32'h12345678, 1'b0, 0);
    txn("sb11",    1'b1, 32'h11,       2'b00, 1'b0, 32'hDEADBE80, 32'h0,        1'b0, 0);
    txn("lb11",    1'b0, 32'h11,       2'b00, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0, 0);
    txn("lbu11",   1'b0, 32'h11,       2'b00, 1'b1, 32'h0,        32'h00000080, 1'b0, 0);
    txn("lb13",    1'b0, 32'h13,       2'b00, 1'b0, 32'h0,        32'h00000012, 1'b0, 0);
    txn("lwu10",   1'b0, 32'h10,       2'b10, 1'b1, 32'h0,        32'h12348078, 1'b0, 0);
    txn("sw20",    1'b1, 32'h20,       2'b10, 1'b0, 32'hAAAAAAAA, 32'h0,        1'b0, 0);
    txn("sh20",    1'b1, 32'h20,       2'b01, 1'b0, 32'h1234BEEF, 32'h0,        1'b0, 0);
    txn("lw20",    1'b0, 32'h20,       2'b10, 1'b0, 32'h0,        32'hAAAABEEF, 1'b0, 0);
    txn("lh20",    1'b0, 32'h20,       2'b01, 1'b0, 32'h0,        32'hFFFFBEEF, 1'b0, 0);
    txn("lhu22",   1'b0, 32'h22,       2'b01, 1'b1, 32'h0,        32'h0000AAAA, 1'b0, 0);
    txn("lh11",    1'b0, 32'h11,       2'b01, 1'b0, 32'h0,        32'h0,        1'b1, 0);
    txn("swffc",   1'b1, 32'hFFC,      2'b10, 1'b0, 32'h11223344, 32'h0,        1'b0, 0);
    txn("swffe",   1'b1, 32'hFFE,      2'b10, 1'b0, 32'hFFFFFFFF, 32'h0,        1'b1, 0);
    txn("lwffc",   1'b0, 32'hFFC,      2'b10, 1'b0, 32'h0,        32'h11223344, 1'b0, 0);
    txn("shffe",   1'b1, 32'hFFE,      2'b01, 1'b0, 32'h00005566, 32'h0,        1'b0, 0);
    txn("lwffc2",  1'b0, 32'hFFC,      2'b10, 1'b0, 32'h0,        32'h55663344, 1'b0, 0);
    txn("lbufff",  1'b0, 32'hFFF,      2'b00, 1'b1, 32'h0,        32'h00000055, 1'b0, 0);
    txn("lb1000",  1'b0, 32'h1000,     2'b00, 1'b0, 32'h0,        32'h0,        1'b1, 0);
    txn("lwwrap",  1'b0, 32'hFFFFFFFC, 2'b10, 1'b0, 32'h0,        32'h0,        1'b1, 0);
    txn("size11",  1'b0, 32'h10,       2'b11, 1'b0, 32'h0,        32'h0,        1'b1, 0);
    txn("sw12mis", 1'b1, 32'h12,       2'b10, 1'b0, 32'h99999999, 32'h0,        1'b1, 0);
    txn("hold",    1'b0, 32'h10,       2'b10, 1'b0, 32'h0,        32'h12348078, 1'b0, 5);

    // Reset during an outstanding LATENCY=4 load.
    @(negedge clk);
    m4.req_valid = 1'b1; m4.req_we = 1'b1; m4.req_addr = 32'h40;
    m4.req_size = 2'b10; m4.req_wdata = 32'hCAFEF00D;
    check_val("l4/ready", {31'd0, m4.req_ready}, 32'd1);
    @(negedge clk);
    m4.req_valid = 1'b0;
    t = 1;
    while (m4.resp_valid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_val("l4/st_latency", 32'(t), LAT4);
    m4.resp_ready = 1'b1;
    @(negedge clk);
    m4.resp_ready = 1'b0;
    m4.req_valid = 1'b1; m4.req_we = 1'b0; m4.req_addr = 32'h40; m4.req_size = 2'b10;
    @(negedge clk);
    m4.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("l4/rst_valid", {31'd0, m4.resp_valid}, 32'd0);
    check_val("l4/rst_ready", {31'd0, m4.req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("l4/ready_after", {31'd0, m4.req_ready}, 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (m4.resp_valid === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    check_val("l4/no_resp", {31'd0, seen}, 32'd0);

    sb_q.push_back({1'b0, 32'hCAFEF00D});
    m4.req_valid = 1'b1; m4.req_we = 1'b0; m4.req_addr = 32'h40; m4.req_size = 2'b10;
    @(negedge clk);
    m4.req_valid = 1'b0;
    t = 1;
    while (m4.resp_valid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_val("l4/ld_latency", 32'(t), LAT4);
    exp = sb_q.pop_front();
    check_val("l4/rdata", m4.resp_rdata, exp[31:0]);
    check_val("l4/fault", {31'd0, m4.resp_fault}, {31'd0, exp[32]});
    m4.resp_ready = 1'b1;
    @(negedge clk);
    m4.resp_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
